vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 40, 128, 88: horizontal front porch, sync and back porch widths in pixels.
REQ-003 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 1, 4, 23: vertical front porch, sync and back porch widths in lines.
REQ-005 Parameters H_SYNC_POL and V_SYNC_POL, default 1 each: asserted level of o_hsync and o_vsync.
REQ-006 i_clk  input  1  system clock, the single clock of the block.
REQ-007 i_rst  input  1  reset, synchronous, active-high.
REQ-008 i_pix_en  input  1  pixel strobe; every clock with i_pix_en=1 advances one pixel.
REQ-009 o_h_coord  output  11  horizontal pixel counter.
REQ-010 o_v_coord  output  10  vertical line counter.
REQ-011 o_disp_enbl  output  1  current coordinate is inside the visible area.
REQ-012 o_frame_start  output  1  current coordinate is (0,0).
REQ-013 i_red, i_green, i_blue  input  4 each  pixel colour for the current coordinate, combinational from o_h_coord/o_v_coord.
REQ-014 o_vga_red, o_vga_green, o_vga_blue  output  4 each  registered colour to the DAC.
REQ-015 o_hsync, o_vsync  output  1 each  registered sync to the connector, aligned with o_vga_*.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
REQ-017 Stage 1: h_cnt and v_cnt registers drive o_h_coord and o_v_coord directly.
REQ-018 On i_pix_en=1: if h_cnt < H_TOTAL-1, h_cnt increments by 1; otherwise h_cnt becomes 0.
REQ-019 On i_pix_en=1 with h_cnt = H_TOTAL-1: if v_cnt < V_TOTAL-1, v_cnt increments by 1; otherwise v_cnt becomes 0.
REQ-020 With i_pix_en=0, all registers hold their values.
REQ-021 o_disp_enbl = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE), combinational from stage 1.
REQ-022 o_frame_start = (h_cnt = 0) and (v_cnt = 0), combinational from stage 1; it stays high for the whole pixel period.
REQ-023 hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 840..967).
REQ-024 vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 601..604), independent of h_cnt.
REQ-025 Stage 2 updates only on i_pix_en=1:
- o_hsync = hs_act ? H_SYNC_POL : not H_SYNC_POL; o_vsync likewise with vs_act and V_SYNC_POL.
- o_vga_* = i_* when o_disp_enbl=1, else 4'h0.
REQ-026 Latency: o_vga_* and o_hsync/o_vsync reflect the coordinate presented one pixel strobe earlier; colour and sync stay mutually aligned.
REQ-027 Outside the visible area, o_vga_* is forced to 0 whatever i_* carries.
REQ-028 Frame wrap (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, i_pix_en=1): both counters go to 0 in the same clock.
REQ-029 Arithmetic: counters are unsigned; comparisons use full counter width; no intermediate value wraps for the default parameters.

Reset
REQ-030 While i_rst=1 at a clock edge, regardless of i_pix_en: h_cnt=0, v_cnt=0, o_vga_*=0, o_hsync=not H_SYNC_POL, o_vsync=not V_SYNC_POL.
REQ-031 Reset value of o_disp_enbl and o_frame_start is 1, as decoded from zeroed counters.
REQ-032 Reset asserted mid-line or mid-frame aborts the frame; the first i_pix_en after deassertion advances h_cnt from 0 to 1.

Verification
REQ-033 Reset then i_pix_en=1 continuously -> o_h_coord runs 0..1055 and wraps; o_v_coord increments once per 1056 clocks; at (1055,627) the next coordinate is (0,0) and o_frame_start=1.
REQ-034 Continuous strobe, one full line -> o_hsync high for exactly 128 clocks, beginning the clock after h_cnt=840 is presented; o_disp_enbl high for exactly 800 clocks.
REQ-035 Full frame -> o_vsync high for 4*1056 clocks, beginning one clock after (0,601); 600 lines contain o_disp_enbl.
REQ-036 i_red/i_green/i_blue tied to 4'hF, 4'h0, 4'hA -> o_vga_* = F,0,A one strobe after a visible coordinate; 0,0,0 one strobe after h_cnt=800.
REQ-037 i_pix_en pulsed every 4th clock -> all outputs hold between strobes; line period is 4224 clocks.
REQ-038 i_rst pulsed for one clock at (500,300) -> next clock shows (0,0), o_vga_*=0, syncs inactive; counting resumes from 0.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel strobe, colour, coordinate and DAC/sync signals of the VGA timing block
interface vga_timing_if;
  logic        i_pix_en;
  logic [3:0]  i_red;
  logic [3:0]  i_green;
  logic [3:0]  i_blue;
  logic [10:0] o_h_coord;
  logic [9:0]  o_v_coord;
  logic        o_disp_enbl;
  logic        o_frame_start;
  logic [3:0]  o_vga_red;
  logic [3:0]  o_vga_green;
  logic [3:0]  o_vga_blue;
  logic        o_hsync;
  logic        o_vsync;
  modport master (
    output i_pix_en, i_red, i_green, i_blue,
    input  o_h_coord, o_v_coord, o_disp_enbl, o_frame_start,
    input  o_vga_red, o_vga_green, o_vga_blue, o_hsync, o_vsync
  );
  modport slave (
    input  i_pix_en, i_red, i_green, i_blue,
    output o_h_coord, o_v_coord, o_disp_enbl, o_frame_start,
    output o_vga_red, o_vga_green, o_vga_blue, o_hsync, o_vsync
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters plus a registered colour/sync stage aligned one pixel strobe behind
module vga_timing #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst,
  vga_timing_if.slave vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        disp, hs_act, vs_act, hsync, vsync;
  logic [3:0]  red, green, blue;
  always_comb begin
    disp   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_act = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_act = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  end
  // Stage 2 samples the colour for the coordinate currently shown, so the DAC lags by one strobe
  always_ff @(posedge i_clk)
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      {red, green, blue} <= 12'h0;
      hsync <= !H_SYNC_POL;
      vsync <= !V_SYNC_POL;
    end else if (vga.i_pix_en) begin
      h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 11'd1;
      if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      hsync <= hs_act ? H_SYNC_POL : !H_SYNC_POL;
      vsync <= vs_act ? V_SYNC_POL : !V_SYNC_POL;
      {red, green, blue} <= disp ? {vga.i_red, vga.i_green, vga.i_blue} : 12'h0;
    end
  assign vga.o_h_coord     = h_cnt;
  assign vga.o_v_coord     = v_cnt;
  assign vga.o_disp_enbl   = disp;
  assign vga.o_frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign vga.o_vga_red     = red;
  assign vga.o_vga_green   = green;
  assign vga.o_vga_blue    = blue;
  assign vga.o_hsync       = hsync;
  assign vga.o_vsync       = vsync;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: default and shrunken-raster instances checked against a pixel-index reference model
module tb_vga_timing;
  typedef struct packed {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hpol, vpol;
  } prm_t;
  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        d, f;
    logic [11:0] col;
    logic        hs, vs;
  } obs_t;
  typedef struct {
    bit r, en;
    int h, v;
    bit d, f;
    logic [11:0] col;
    bit hs, vs;
  } vec_t;
  localparam prm_t PD = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam prm_t PS = '{6, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b1};
  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0, cmode = 1'b1;
  int passed = 0, total = 0;
  int p = 0;
  bit st = 1'b0, lcm = 1'b1;
  obs_t od, os;
  vec_t tbl[15];
  vga_timing_if ifd ();
  vga_timing_if ifs ();
  vga_timing dut_d (.i_clk(clk), .i_rst(rst), .vga(ifd));
  vga_timing #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
  ) dut_s (.i_clk(clk), .i_rst(rst), .vga(ifs));
  always #5 clk = ~clk;
  function automatic logic [11:0] colour(input int h, input int v, input bit cm);
    return cm ? 12'hF0A : 12'(h * 37 + v * 91);
  endfunction
  assign ifd.i_pix_en = pix_en;
  assign ifs.i_pix_en = pix_en;
  assign {ifd.i_red, ifd.i_green, ifd.i_blue} = colour(int'(ifd.o_h_coord), int'(ifd.o_v_coord), cmode);
  assign {ifs.i_red, ifs.i_green, ifs.i_blue} = colour(int'(ifs.o_h_coord), int'(ifs.o_v_coord), cmode);
  assign od = {ifd.o_h_coord, ifd.o_v_coord, ifd.o_disp_enbl, ifd.o_frame_start,
               ifd.o_vga_red, ifd.o_vga_green, ifd.o_vga_blue, ifd.o_hsync, ifd.o_vsync};
  assign os = {ifs.o_h_coord, ifs.o_v_coord, ifs.o_disp_enbl, ifs.o_frame_start,
               ifs.o_vga_red, ifs.o_vga_green, ifs.o_vga_blue, ifs.o_hsync, ifs.o_vsync};
  // Expected outputs after p strobes since reset: coordinates from p, stage 2 from strobe p-1
  function automatic obs_t model(input prm_t pr, input int n, input bit s, input bit cm);
    int ht, vt, h, v, hq, vq;
    obs_t e;
    ht = pr.ha + pr.hfp + pr.hsw + pr.hbp;
    vt = pr.va + pr.vfp + pr.vsw + pr.vbp;
    h = n % ht;
    v = (n / ht) % vt;
    e.h = 11'(h);
    e.v = 10'(v);
    e.d = (h < pr.ha) && (v < pr.va);
    e.f = (h == 0) && (v == 0);
    e.col = 12'h0;
    e.hs = !pr.hpol;
    e.vs = !pr.vpol;
    if (s) begin
      hq = (n - 1) % ht;
      vq = ((n - 1) / ht) % vt;
      if (hq < pr.ha && vq < pr.va) e.col = colour(hq, vq, cm);
      if (hq >= pr.ha + pr.hfp && hq < pr.ha + pr.hfp + pr.hsw) e.hs = pr.hpol;
      if (vq >= pr.va + pr.vfp && vq < pr.va + pr.vfp + pr.vsw) e.vs = pr.vpol;
    end
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    else passed++;
  endtask
  task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, "_h"}, 32'(a.h), 32'(e.h));
    chk({tag, "_v"}, 32'(a.v), 32'(e.v));
    chk({tag, "_disp"}, 32'(a.d), 32'(e.d));
    chk({tag, "_fs"}, 32'(a.f), 32'(e.f));
    chk({tag, "_rgb"}, 32'(a.col), 32'(e.col));
    chk({tag, "_hs"}, 32'(a.hs), 32'(e.hs));
    chk({tag, "_vs"}, 32'(a.vs), 32'(e.vs));
  endtask
  task automatic step(input bit r, input bit en, input bit cm);
    @(negedge clk);
    rst = r;
    pix_en = en;
    cmode = cm;
    @(posedge clk);
    if (r) begin
      p = 0;
      st = 1'b0;
    end else if (en) begin
      p++;
      st = 1'b1;
      lcm = cm;
    end
    #1;
    chk_obs("dflt", od, model(PD, p, st, lcm));
    chk_obs("small", os, model(PS, p, st, lcm));
  endtask
  initial begin
    int hs_cnt, de_cnt, vs_cnt, first_hs, wrap_at;
    tbl[0]  = '{1, 1, 0, 0, 1, 1, 12'h000, 1, 0};
    tbl[1]  = '{0, 1, 1, 0, 1, 0, 12'hF0A, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 0, 12'hF0A, 1, 0};
    tbl[3]  = '{0, 1, 2, 0, 1, 0, 12'hF0A, 1, 0};
    tbl[4]  = '{0, 1, 3, 0, 1, 0, 12'hF0A, 1, 0};
    tbl[5]  = '{0, 1, 4, 0, 1, 0, 12'hF0A, 1, 0};
    tbl[6]  = '{0, 1, 5, 0, 1, 0, 12'hF0A, 1, 0};
    tbl[7]  = '{0, 1, 6, 0, 0, 0, 12'hF0A, 1, 0};
    tbl[8]  = '{0, 1, 7, 0, 0, 0, 12'h000, 1, 0};
    tbl[9]  = '{0, 1, 8, 0, 0, 0, 12'h000, 1, 0};
    tbl[10] = '{0, 1, 9, 0, 0, 0, 12'h000, 0, 0};
    tbl[11] = '{0, 1, 10, 0, 0, 0, 12'h000, 0, 0};
    tbl[12] = '{0, 1, 11, 0, 0, 0, 12'h000, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 1, 0, 12'h000, 1, 0};
    tbl[14] = '{0, 1, 1, 1, 1, 0, 12'hF0A, 1, 0};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].en, 1'b1);
      chk("tbl_h", 32'(os.h), 32'(tbl[i].h));
      chk("tbl_v", 32'(os.v), 32'(tbl[i].v));
      chk("tbl_disp", 32'(os.d), 32'(tbl[i].d));
      chk("tbl_fs", 32'(os.f), 32'(tbl[i].f));
      chk("tbl_rgb", 32'(os.col), 32'(tbl[i].col));
      chk("tbl_hs", 32'(os.hs), 32'(tbl[i].hs));
      chk("tbl_vs", 32'(os.vs), 32'(tbl[i].vs));
    end
    // One default-size line with a continuous strobe
    step(1'b1, 1'b0, 1'b1);
    hs_cnt = 0;
    de_cnt = 0;
    first_hs = -1;
    for (int i = 0; i < 1056; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (od.hs) hs_cnt++;
      if (od.hs && first_hs < 0) first_hs = int'(od.h);
      if (od.d) de_cnt++;
      if (od.h == 11'd801) chk("line_rgb_after_800", 32'(od.col), 32'h0);
    end
    chk("line_hs_width", 32'(hs_cnt), 32'd128);
    chk("line_hs_first", 32'(first_hs), 32'd841);
    chk("line_de_width", 32'(de_cnt), 32'd800);
    chk("line_wrap_h", 32'(od.h), 32'd0);
    chk("line_wrap_v", 32'(od.v), 32'd1);
    // Strobe every fourth clock: one line spans 4224 clocks
    step(1'b1, 1'b0, 1'b0);
    wrap_at = -1;
    for (int i = 0; i < 4224; i++) begin
      step(1'b0, (i % 4) == 3, 1'b0);
      if (wrap_at < 0 && od.v == 10'd1) wrap_at = i;
    end
    chk("slow_line_period", 32'(wrap_at), 32'd4223);
    // Whole shrunken frame: wrap to (0,0) and vsync width of two 12-pixel lines
    step(1'b1, 1'b1, 1'b0);
    vs_cnt = 0;
    hs_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (os.vs) vs_cnt++;
      if (!os.hs) hs_cnt++;
    end
    chk("frame_vs_width", 32'(vs_cnt), 32'd24);
    chk("frame_hs_width", 32'(hs_cnt), 32'd24);
    chk("frame_wrap_fs", 32'(os.f), 32'd1);
    chk("frame_wrap_hv", 32'({os.h, os.v}), 32'd0);
    // Reset in the middle of a frame aborts it
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_hv", 32'({od.h, od.v}), 32'd0);
    chk("midrst_rgb", 32'(od.col), 32'h0);
    chk("midrst_hs", 32'(os.hs), 32'd1);
    chk("midrst_vs", 32'(os.vs), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("midrst_resume", 32'(od.h), 32'd1);
    // Random strobes, occasional resets and colour-source switches
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 2999) == 0, $urandom_range(0, 9) < 7,
           ($urandom_range(0, 63) == 0) ? !cmode : cmode);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
